neuron_seq: RTL and testbench

- Sequencer directly upstream of the neuron MAC datapath.
- On a start request for one neuron:
  - clears the accumulator;
  - streams N (input, weight) sign-magnitude byte pairs from synchronous-read memories into the datapath with one load per cycle;
  - captures the activation result;
  - presents the result on a valid/ready handshake to the next layer.

---
 rtl/neuron_seq_if.sv | 11 +
 rtl/neuron_seq.sv | 176 +++++++++++++++++
 tb/tb_neuron_seq.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_seq_if.sv
// Result handshake between the neuron sequencer (master) and the next layer (slave).
// result_valid/result_ready: a transfer happens on any rising edge where both are high.
interface neuron_seq_if;
    logic [15:0] result;
    logic [15:0] result_idx;
    logic        result_valid;
    logic        result_ready;

    modport master (output result, result_idx, result_valid, input result_ready);
    modport slave  (input result, result_idx, result_valid, output result_ready);
endinterface

// File: rtl/neuron_seq.sv
// Sequencer feeding one neuron's (input, weight) pairs into the MAC datapath and handing off the result.
// Optional abort input (CLR/MAC/CAP -> IDLE) is compiled in with NEURON_SEQ_ABORT_EN.
module neuron_seq #(
    parameter int N   = 16,
    parameter int AW  = 4,
    parameter int WAW = 16
) (
    input  logic           clk,
    input  logic           reg_rst,
    input  logic           start,
    input  logic [15:0]    neuron_idx,
`ifdef NEURON_SEQ_ABORT_EN
    input  logic           abort,
`endif
    output logic [AW-1:0]  in_addr,
    output logic [WAW-1:0] w_addr,
    input  logic [7:0]     in_data,
    input  logic [7:0]     w_data,
    output logic [7:0]     dp_in,
    output logic [7:0]     dp_w,
    output logic           dp_ld,
    output logic           acc_clr,
    input  logic [15:0]    dp_res,
    output logic           busy,
    output logic [2:0]     state_dbg,
    neuron_seq_if.master   res
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        MAC  = 3'd2,
        CAP  = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST      = AW'(N - 1);
    localparam logic [AW-1:0] FIRST_ADV = (N > 1) ? AW'(1) : AW'(0);

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  in_addr_q, in_addr_d;
    logic [WAW-1:0] w_addr_q, w_addr_d;
    logic [WAW-1:0] base_q, base_d;
    logic [15:0]    idx_q, idx_d;
    logic [15:0]    result_q, result_d;
    logic [15:0]    result_idx_q, result_idx_d;
    logic           valid_q, valid_d;
    logic           dp_ld_q, dp_ld_d;
    logic           acc_clr_q, acc_clr_d;

    logic [AW:0]    cnt_p2;
    logic [AW-1:0]  adv_addr;
    logic [WAW-1:0] base_start;
    logic           abort_hit;

    assign base_start = WAW'(32'(neuron_idx) * 32'(N));
    // Memories are one cycle behind the address, so MAC pair c presents address c+1 (clamped at the last pair).
    assign cnt_p2     = {1'b0, cnt_q} + (AW + 1)'(2);
    assign adv_addr   = (cnt_p2 <= {1'b0, LAST}) ? cnt_p2[AW-1:0] : LAST;

`ifdef NEURON_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q inside {CLR, MAC, CAP});
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_addr_d    = in_addr_q;
        w_addr_d     = w_addr_q;
        base_d       = base_q;
        idx_d        = idx_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;
        valid_d      = valid_q;
        dp_ld_d      = 1'b0;
        acc_clr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLR;
                    idx_d     = neuron_idx;
                    base_d    = base_start;
                    cnt_d     = '0;
                    in_addr_d = '0;
                    w_addr_d  = base_start;
                    acc_clr_d = 1'b1;
                end
            end
            CLR: begin
                state_d   = MAC;
                cnt_d     = '0;
                dp_ld_d   = 1'b1;
                in_addr_d = FIRST_ADV;
                w_addr_d  = base_q + WAW'(FIRST_ADV);
            end
            MAC: begin
                if (cnt_q == LAST) begin
                    state_d = CAP;
                end else begin
                    cnt_d     = cnt_q + AW'(1);
                    dp_ld_d   = 1'b1;
                    in_addr_d = adv_addr;
                    w_addr_d  = base_q + WAW'(adv_addr);
                end
            end
            CAP: begin
                state_d      = HOLD;
                result_d     = dp_res;
                result_idx_d = idx_q;
                valid_d      = 1'b1;
            end
            HOLD: begin
                if (valid_q && res.result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort discards the partial sum: clear the accumulator once and skip capture.
        if (abort_hit) begin
            state_d      = IDLE;
            dp_ld_d      = 1'b0;
            acc_clr_d    = 1'b1;
            result_d     = result_q;
            result_idx_d = result_idx_q;
            valid_d      = valid_q;
        end
    end

    always_ff @(posedge clk or negedge reg_rst) begin
        if (!reg_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_addr_q    <= '0;
            w_addr_q     <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            result_q     <= '0;
            result_idx_q <= '0;
            valid_q      <= 1'b0;
            dp_ld_q      <= 1'b0;
            acc_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_addr_q    <= in_addr_d;
            w_addr_q     <= w_addr_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
            valid_q      <= valid_d;
            dp_ld_q      <= dp_ld_d;
            acc_clr_q    <= acc_clr_d;
        end
    end

    assign in_addr          = in_addr_q;
    assign w_addr           = w_addr_q;
    assign dp_in            = in_data;
    assign dp_w             = w_data;
    assign dp_ld            = dp_ld_q;
    assign acc_clr          = acc_clr_q;
    assign busy             = (state_q != IDLE);
    assign state_dbg        = state_q;
    assign res.result       = result_q;
    assign res.result_idx   = result_idx_q;
    assign res.result_valid = valid_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: memories and a pass-through MAC stub around the DUT, with a result scoreboard.
module tb_neuron_seq;
    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int WAW = 16;

    logic           clk = 1'b0;
    logic           reg_rst = 1'b1;
    logic           start = 1'b0;
    logic [15:0]    neuron_idx = '0;
    logic           ready = 1'b1;
    logic [AW-1:0]  in_addr;
    logic [WAW-1:0] w_addr;
    logic [7:0]     in_data = '0;
    logic [7:0]     w_data = '0;
    logic [7:0]     dp_in, dp_w;
    logic           dp_ld, acc_clr, busy;
    logic [2:0]     state_dbg;
    logic [15:0]    acc = '0;
`ifdef NEURON_SEQ_ABORT_EN
    logic           abort = 1'b0;
`endif

    logic [7:0]     in_mem [0:(1<<AW)-1];
    logic [7:0]     w_mem  [0:(1<<WAW)-1];
    logic [31:0]    exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int clr_total = 0;
    int ld_cnt   = 0;
    int clr_edge = 0;
    logic [15:0] cur_base = '0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    neuron_seq_if res_if ();
    assign res_if.result_ready = ready;

    neuron_seq #(.N(N), .AW(AW), .WAW(WAW)) dut (
        .clk        (clk),
        .reg_rst    (reg_rst),
        .start      (start),
        .neuron_idx (neuron_idx),
`ifdef NEURON_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .in_addr    (in_addr),
        .w_addr     (w_addr),
        .in_data    (in_data),
        .w_data     (w_data),
        .dp_in      (dp_in),
        .dp_w       (dp_w),
        .dp_ld      (dp_ld),
        .acc_clr    (acc_clr),
        .dp_res     (acc),
        .busy       (busy),
        .state_dbg  (state_dbg),
        .res        (res_if)
    );

    function automatic int sm_val(input logic [7:0] b);
        return b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    endfunction

    // Synchronous-read memories and a datapath whose activation is the raw accumulator.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        if (acc_clr)
            acc <= '0;
        else if (dp_ld)
            acc <= acc + 16'(sm_val(dp_in) * sm_val(dp_w));
        cyc <= cyc + 1;
    end

    function automatic logic [15:0] ref_neuron(input logic [15:0] idx);
        int sum;
        int base;
        sum  = 0;
        base = (int'(idx) * N) % 65536;
        for (int i = 0; i < N; i++)
            sum += sm_val(in_mem[i]) * sm_val(w_mem[(base + i) % 65536]);
        return 16'(sum);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input logic [15:0] idx);
        exp_q.push_back({idx, ref_neuron(idx)});
    endtask

    task automatic fill_rand(input logic [15:0] idx);
        int base;
        base = (int'(idx) * N) % 65536;
        for (int i = 0; i < N; i++) begin
            in_mem[i] = 8'($urandom_range(0, 255));
            w_mem[(base + i) % 65536] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic issue(input logic [15:0] idx);
        @(posedge clk); #1;
        neuron_idx = idx;
        start = 1'b1;
        push_exp(idx);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && !busy) break;
        end
        ready = 1'b1;
        if (k == budget) fail_now("timeout_done");
    endtask

    task automatic wait_loads(input int target, input int budget);
        int k;
        int seen;
        seen = 0;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (dp_ld) seen++;
            if (seen == target) break;
        end
        if (k == budget) fail_now("timeout_loads");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_addr"}, 32'(in_addr), 0);
        check({tag, "_w_addr"}, 32'(w_addr), 0);
        check({tag, "_dp_ld"}, 32'(dp_ld), 0);
        check({tag, "_acc_clr"}, 32'(acc_clr), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(res_if.result_valid), 0);
        check({tag, "_result"}, 32'(res_if.result), 0);
        check({tag, "_result_idx"}, 32'(res_if.result_idx), 0);
    endtask

    // Monitor: address sequence, load count, latency and result against the scoreboard.
    always @(negedge clk) begin
        if (!reg_rst) begin
            prev_valid = 1'b0;
        end else begin
            if (acc_clr) clr_total++;
            if (acc_clr && busy) begin
                if (exp_q.size() == 0) fail_now("unexpected_start");
                else cur_base = 16'(int'(exp_q[0][31:16]) * N);
                ld_cnt   = 0;
                clr_edge = cyc;
                check("clr_in_addr", 32'(in_addr), 0);
                check("clr_w_addr", 32'(w_addr), 32'(cur_base));
            end
            if (dp_ld) begin
                int a;
                a = (ld_cnt + 1 < N) ? ld_cnt + 1 : N - 1;
                check("mac_in_addr", 32'(in_addr), 32'(a));
                check("mac_w_addr", 32'(w_addr), 32'(16'(cur_base + 16'(a))));
                ld_cnt++;
            end
            if (res_if.result_valid) begin
                if (!prev_valid) begin
                    check("latency", 32'(cyc - clr_edge), 32'(N + 2));
                    check("ld_count", 32'(ld_cnt), 32'(N));
                end
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("result", 32'(res_if.result), 32'(exp_q[0][15:0]));
                    check("result_idx", 32'(res_if.result_idx), 32'(exp_q[0][31:16]));
                    if (ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = res_if.result_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr0;
        int gap;
        int k;
        for (int i = 0; i < (1 << AW); i++) in_mem[i] = '0;
        for (int i = 0; i < (1 << WAW); i++) w_mem[i] = '0;

        #1 reg_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reg_rst = 1'b1;

        // Directed: 8 + 6 - 7 + 5 = 12
        in_mem[0] = 8'h02; in_mem[1] = 8'h03; in_mem[2] = 8'h81; in_mem[3] = 8'h05;
        w_mem[0]  = 8'h04; w_mem[1]  = 8'h02; w_mem[2]  = 8'h07; w_mem[3]  = 8'h01;
        issue(16'd0);
        wait_done(60, 1'b0);

        fill_rand(16'd3);
        issue(16'd3);
        wait_done(60, 1'b0);

        // Stall in HOLD with a stray start pulse that must be ignored.
        fill_rand(16'd5);
        clr0 = clr_total;
        ready = 1'b0;
        issue(16'd5);
        for (k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (res_if.result_valid) break;
        end
        if (k == 30) fail_now("timeout_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            neuron_idx = 16'd9;
            start = (i == 1);
        end
        start = 1'b0;
        ready = 1'b1;
        wait_done(30, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored_busy", 32'(busy), 0);
        check("stall_clr_pulses", 32'(clr_total - clr0), 1);

        // start held high across two neurons.
        for (int i = 0; i < N; i++) begin
            in_mem[i] = 8'($urandom_range(0, 255));
            w_mem[N + i] = 8'($urandom_range(0, 255));
            w_mem[2 * N + i] = 8'($urandom_range(0, 255));
        end
        clr0 = clr_total;
        @(posedge clk); #1;
        neuron_idx = 16'd1;
        start = 1'b1;
        push_exp(16'd1);
        for (k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (busy) break;
        end
        if (k == 10) fail_now("timeout_busy");
        neuron_idx = 16'd2;
        push_exp(16'd2);
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        if (k == 40) fail_now("timeout_first_done");
        gap = 1;
        for (k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (busy) break;
            gap++;
        end
        check("idle_gap", 32'(gap), 1);
        start = 1'b0;
        wait_done(40, 1'b0);
        check("held_clr_pulses", 32'(clr_total - clr0), 2);

        // Asynchronous reset during MAC c=2, then a clean rerun.
        fill_rand(16'd6);
        issue(16'd6);
        wait_loads(3, 20);
        #2 reg_rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reg_rst = 1'b1;
        issue(16'd6);
        wait_done(60, 1'b0);

        // Random neurons with random back-pressure.
        for (int n = 0; n < 10; n++) begin
            logic [15:0] idx;
            idx = 16'($urandom_range(0, 65535));
            fill_rand(idx);
            issue(idx);
            wait_done(200, 1'b1);
        end

`ifdef NEURON_SEQ_ABORT_EN
        fill_rand(16'd7);
        clr0 = clr_total;
        issue(16'd7);
        wait_loads(2, 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_dp_ld", 32'(dp_ld), 0);
        check("abort_acc_clr", 32'(acc_clr), 1);
        check("abort_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("abort_clr_single", 32'(acc_clr), 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_valid", 32'(res_if.result_valid), 0);
        check("abort_clr_pulses", 32'(clr_total - clr0), 2);
`endif

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
